// File: rtl/x_micro_sequencer_param_pkg.sv
// Shared types for the parametrised micro-sequencer: command codes, FSM states
// and the default-width instruction word layout.
package x_micro_sequencer_param_pkg;

   localparam int CMD_W      = 4;
   localparam int DEF_DATA_W = 36;
   localparam int DEF_ADDR_W = 9;

   typedef enum logic [CMD_W-1:0] {
      CMD_NOP       = 4'd0,
      CMD_OUT       = 4'd1,
      CMD_WAIT      = 4'd2,
      CMD_JUMP      = 4'd3,
      CMD_HALT      = 4'd4,
      CMD_LOOP_SET  = 4'd5,
      CMD_LOOP_BACK = 4'd6
   } cmd_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_EXEC,
      ST_WAIT
   } state_e;

   // Instruction word at the default data width; the command sits in the top bits.
   typedef struct packed {
      cmd_e                  cmd;
      logic [DEF_DATA_W-1:0] data;
   } instr_t;

endpackage

// File: rtl/x_seq_prog_ram.sv
// Program store for the micro-sequencer: one write port, one read port,
// read data registered (one cycle latency, old data on same-address collision).
module x_seq_prog_ram #(
   parameter int ADDR_W = 9,
   parameter int WORD_W = 40
) (
   input  logic              i_clk,
   input  logic              i_wen,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [WORD_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [WORD_W-1:0] o_rdata
);

   logic [WORD_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge i_clk) begin
      if (i_wen) begin
         mem[i_waddr] <= i_wdata;
      end
      o_rdata <= mem[i_raddr];
   end

endmodule

// File: rtl/x_micro_sequencer_param.sv
// Parametrised micro-sequencer: runs a {command, data} program from address 0 on start.
// Define X_MICRO_SEQ_LOOP_EN to enable the counted-loop commands LOOP_SET/LOOP_BACK.
module x_micro_sequencer_param
   import x_micro_sequencer_param_pkg::*;
#(
   parameter int DATA_W = 36,
   parameter int ADDR_W = 9
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic              i_abort,
   output logic              o_busy,
   output logic              o_done,
   input  logic              i_wen,
   input  logic [CMD_W-1:0]  i_wcmd,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_waddr,
   output logic [DATA_W-1:0] o_data,
   output logic [ADDR_W-1:0] o_pc
);

   localparam int WORD_W = CMD_W + DATA_W;
   localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
   localparam logic [DATA_W-1:0] DATA_ONE = DATA_W'(1);

   typedef struct packed {
      cmd_e              cmd;
      logic [DATA_W-1:0] data;
   } instr_w_t;

   state_e            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] jump_target;
   logic [DATA_W-1:0] wait_cnt;
   logic [WORD_W-1:0] rd_word;
   logic              ram_wen;
   instr_w_t          instr;
`ifdef X_MICRO_SEQ_LOOP_EN
   logic [DATA_W-1:0] loop_cnt;
`endif

   // The program can only be rewritten while the sequencer is idle.
   assign ram_wen     = i_wen & ~o_busy;
   assign instr       = instr_w_t'(rd_word);
   assign pc_inc      = pc + PC_ONE;
   assign jump_target = instr.data[ADDR_W-1:0];
   assign o_pc        = pc;

   x_seq_prog_ram #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_prog_ram (
      .i_clk   (i_clk),
      .i_wen   (ram_wen),
      .i_waddr (i_waddr),
      .i_wdata ({i_wcmd, i_wdata}),
      .i_raddr (pc),
      .o_rdata (rd_word)
   );

   // Abort outranks everything; EXEC retires the fetched instruction.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state    <= ST_IDLE;
         pc       <= '0;
         wait_cnt <= '0;
`ifdef X_MICRO_SEQ_LOOP_EN
         loop_cnt <= '0;
`endif
         o_data   <= '0;
         o_done   <= 1'b0;
         o_busy   <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_abort) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (i_start) begin
                     state  <= ST_FETCH;
                     pc     <= '0;
                     o_busy <= 1'b1;
                  end
               end
               ST_FETCH: begin
                  state <= ST_EXEC;
               end
               ST_EXEC: begin
                  state <= ST_FETCH;
                  pc    <= pc_inc;
                  case (instr.cmd)
                     CMD_OUT: begin
                        o_data <= instr.data;
                     end
                     CMD_WAIT: begin
                        if (instr.data != '0) begin
                           state    <= ST_WAIT;
                           wait_cnt <= instr.data;
                           pc       <= pc;
                        end
                     end
                     CMD_JUMP: begin
                        pc <= jump_target;
                     end
                     CMD_HALT: begin
                        state  <= ST_IDLE;
                        pc     <= pc;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                     end
`ifdef X_MICRO_SEQ_LOOP_EN
                     CMD_LOOP_SET: begin
                        loop_cnt <= instr.data;
                     end
                     CMD_LOOP_BACK: begin
                        if (loop_cnt != '0) begin
                           loop_cnt <= loop_cnt - DATA_ONE;
                           pc       <= jump_target;
                        end
                     end
`else
                     CMD_LOOP_SET, CMD_LOOP_BACK: begin
                     end
`endif
                     default: begin
                     end
                  endcase
               end
               ST_WAIT: begin
                  if (wait_cnt == DATA_ONE) begin
                     state    <= ST_FETCH;
                     pc       <= pc_inc;
                     wait_cnt <= '0;
                  end else begin
                     wait_cnt <= wait_cnt - DATA_ONE;
                  end
               end
               default: begin
                  state  <= ST_IDLE;
                  o_busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_x_micro_sequencer_param.sv
// Self-checking bench for x_micro_sequencer_param: fixed program table, hand-built
// corner sequences, and random programs compared edge by edge with an instruction-level model.
module tb_x_micro_sequencer_param;

   localparam int DW    = 36;
   localparam int AW    = 9;
   localparam int DEPTH = 2**AW;

   localparam logic [3:0] C_NOP  = 4'd0;
   localparam logic [3:0] C_OUT  = 4'd1;
   localparam logic [3:0] C_WAIT = 4'd2;
   localparam logic [3:0] C_JUMP = 4'd3;
   localparam logic [3:0] C_HALT = 4'd4;
   localparam logic [3:0] C_LSET = 4'd5;
   localparam logic [3:0] C_LBCK = 4'd6;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic          busy;
   logic          done;
   logic          wen;
   logic [3:0]    wcmd;
   logic [DW-1:0] wdata;
   logic [AW-1:0] waddr;
   logic [DW-1:0] data;
   logic [AW-1:0] pc;

   int n_checks = 0;
   int n_fail   = 0;

   logic [3:0]    mem_cmd  [DEPTH];
   logic [DW-1:0] mem_data [DEPTH];

   bit            q_busy [$];
   bit            q_done [$];
   logic [DW-1:0] q_data [$];
   int            q_pc   [$];
   bit            m_halted;
   int            m_abort_edge;

   typedef struct {
      logic [3:0][3:0]    c;
      logic [3:0][DW-1:0] d;
      int                 exp_done;
      logic [DW-1:0]      exp_data;
   } vec_t;

   vec_t vecs [8];

   x_micro_sequencer_param #(
      .DATA_W (DW),
      .ADDR_W (AW)
   ) dut (
      .i_clk   (clk),
      .i_rst   (rst),
      .i_start (start),
      .i_abort (abort),
      .o_busy  (busy),
      .o_done  (done),
      .i_wen   (wen),
      .i_wcmd  (wcmd),
      .i_wdata (wdata),
      .i_waddr (waddr),
      .o_data  (data),
      .o_pc    (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic doReset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic writeWord(input int addr, input logic [3:0] c, input logic [DW-1:0] d);
      wen   = 1'b1;
      waddr = AW'(addr);
      wcmd  = c;
      wdata = d;
      tick();
      wen = 1'b0;
      mem_cmd[addr]  = c;
      mem_data[addr] = d;
   endtask

   // Start pulse; returns just after the start edge (edge 0).
   task automatic applyStimulus();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic runUntilDone(input int budget, output int edge_n);
      edge_n = -1;
      for (int k = 1; k <= budget; k++) begin
         tick();
         if (done) begin
            edge_n = k;
            break;
         end
      end
   endtask

   function automatic vec_t mkVec(input logic [3:0] c0, input logic [DW-1:0] d0,
                                  input logic [3:0] c1, input logic [DW-1:0] d1,
                                  input logic [3:0] c2, input logic [DW-1:0] d2,
                                  input logic [3:0] c3, input logic [DW-1:0] d3,
                                  input int exp_done, input logic [DW-1:0] exp_data);
      vec_t v;
      v.c[0] = c0; v.d[0] = d0;
      v.c[1] = c1; v.d[1] = d1;
      v.c[2] = c2; v.d[2] = d2;
      v.c[3] = c3; v.d[3] = d3;
      v.exp_done = exp_done;
      v.exp_data = exp_data;
      return v;
   endfunction

   function automatic void push(input bit b, input bit dn, input logic [DW-1:0] dv, input int p);
      q_busy.push_back(b);
      q_done.push_back(dn);
      q_data.push_back(dv);
      q_pc.push_back(p);
   endfunction

   // Instruction-level interpreter: one queue entry per clock edge after start.
   function automatic void modelRun(input int lim);
      int            mpc;
      logic [DW-1:0] dv;
      logic [3:0]    c;
      logic [DW-1:0] d;
`ifdef X_MICRO_SEQ_LOOP_EN
      logic [DW-1:0] lc;
      lc = '0;
`endif
      q_busy.delete(); q_done.delete(); q_data.delete(); q_pc.delete();
      mpc = 0;
      dv = '0;
      m_halted = 1'b0;
      push(1'b1, 1'b0, dv, mpc);
      while (!m_halted && q_busy.size() < lim) begin
         c = mem_cmd[mpc];
         d = mem_data[mpc];
         push(1'b1, 1'b0, dv, mpc);
         case (c)
            C_OUT: begin
               dv = d;
               mpc = (mpc + 1) % DEPTH;
               push(1'b1, 1'b0, dv, mpc);
            end
            C_WAIT: begin
               for (int k = 0; k < int'(d); k++) push(1'b1, 1'b0, dv, mpc);
               mpc = (mpc + 1) % DEPTH;
               push(1'b1, 1'b0, dv, mpc);
            end
            C_JUMP: begin
               mpc = int'(d % DEPTH);
               push(1'b1, 1'b0, dv, mpc);
            end
            C_HALT: begin
               m_halted = 1'b1;
               push(1'b0, 1'b1, dv, mpc);
               push(1'b0, 1'b0, dv, mpc);
            end
`ifdef X_MICRO_SEQ_LOOP_EN
            C_LSET: begin
               lc = d;
               mpc = (mpc + 1) % DEPTH;
               push(1'b1, 1'b0, dv, mpc);
            end
            C_LBCK: begin
               if (lc != 0) begin
                  lc = lc - 1;
                  mpc = int'(d % DEPTH);
               end else begin
                  mpc = (mpc + 1) % DEPTH;
               end
               push(1'b1, 1'b0, dv, mpc);
            end
`endif
            default: begin
               mpc = (mpc + 1) % DEPTH;
               push(1'b1, 1'b0, dv, mpc);
            end
         endcase
      end
      if (m_halted) begin
         m_abort_edge = -1;
      end else begin
         m_abort_edge = q_busy.size();
         push(1'b0, 1'b0, dv, mpc);
      end
   endfunction

   task automatic runModelCheck(input string tag, input int lim);
      modelRun(lim);
      doReset();
      applyStimulus();
      for (int e = 0; e < q_busy.size(); e++) begin
         if (e > 0) begin
            if (e == m_abort_edge) abort = 1'b1;
            tick();
            abort = 1'b0;
         end
         checkOutput($sformatf("%s e%0d busy", tag, e), 64'(busy), 64'(q_busy[e]));
         checkOutput($sformatf("%s e%0d done", tag, e), 64'(done), 64'(q_done[e]));
         checkOutput($sformatf("%s e%0d data", tag, e), 64'(data), 64'(q_data[e]));
         if (q_busy[e]) checkOutput($sformatf("%s e%0d pc", tag, e), 64'(pc), 64'(q_pc[e]));
      end
   endtask

   task automatic genProgram();
      logic [3:0]    c;
      logic [DW-1:0] d;
      int            r;
      for (int a = 0; a < 16; a++) begin
         r = int'($urandom_range(0, 9));
         d = {4'($urandom), 32'($urandom)};
         case (r)
            0:       c = C_NOP;
            1, 2, 9: c = C_OUT;
            3:       begin c = C_WAIT; d = DW'($urandom_range(0, 4)); end
            4:       begin c = C_JUMP; d = {27'($urandom), 9'($urandom_range(0, 15))}; end
            5:       c = C_HALT;
            6:       begin c = C_LSET; d = DW'($urandom_range(0, 3)); end
            7:       begin c = C_LBCK; d = {27'($urandom), 9'($urandom_range(0, 15))}; end
            default: c = 4'($urandom_range(7, 15));
         endcase
         if (a == 15) begin
            if ($urandom_range(0, 1) == 0) begin
               c = C_HALT;
            end else begin
               c = C_JUMP;
               d = {27'($urandom), 9'($urandom_range(0, 14))};
            end
         end
         writeWord(a, c, d);
      end
   endtask

   initial begin
      int e;
      rst = 1'b0; start = 1'b0; abort = 1'b0; wen = 1'b0;
      wcmd = '0; wdata = '0; waddr = '0;

      vecs[0] = mkVec(C_OUT, 36'h5, C_OUT, 36'hA, C_HALT, 36'h0, C_NOP, 36'h0, 6, 36'hA);
      vecs[1] = mkVec(C_WAIT, 36'h3, C_OUT, 36'h1, C_HALT, 36'h0, C_NOP, 36'h0, 9, 36'h1);
      vecs[2] = mkVec(C_NOP, 36'h0, C_JUMP, 36'h3, C_OUT, 36'h9, C_HALT, 36'h0, 6, 36'h0);
      vecs[3] = mkVec(C_WAIT, 36'h0, C_OUT, 36'h3C, C_HALT, 36'h0, C_NOP, 36'h0, 6, 36'h3C);
`ifdef X_MICRO_SEQ_LOOP_EN
      vecs[4] = mkVec(C_LSET, 36'h2, C_OUT, 36'h7, C_LBCK, 36'h1, C_HALT, 36'h0, 16, 36'h7);
`else
      vecs[4] = mkVec(C_LSET, 36'h2, C_OUT, 36'h7, C_LBCK, 36'h1, C_HALT, 36'h0, 8, 36'h7);
`endif
      vecs[5] = mkVec(4'hF, 36'h0, C_OUT, 36'h55, C_HALT, 36'h0, C_NOP, 36'h0, 6, 36'h55);
      vecs[6] = mkVec(C_HALT, 36'h0, C_OUT, 36'h1, C_NOP, 36'h0, C_NOP, 36'h0, 2, 36'h0);
      vecs[7] = mkVec(C_OUT, 36'hF_FFFF_FFFF, C_HALT, 36'h0, C_NOP, 36'h0, C_NOP, 36'h0, 4, 36'hF_FFFF_FFFF);

      doReset();
      checkOutput("reset busy", 64'(busy), 64'h0);
      checkOutput("reset done", 64'(done), 64'h0);
      checkOutput("reset data", 64'(data), 64'h0);
      checkOutput("reset pc",   64'(pc),   64'h0);

      for (int i = 0; i < 8; i++) begin
         doReset();
         for (int a = 0; a < 4; a++) writeWord(a, vecs[i].c[a], vecs[i].d[a]);
         applyStimulus();
         runUntilDone(60, e);
         checkOutput($sformatf("vec%0d done edge", i), 64'(e), 64'(vecs[i].exp_done));
         checkOutput($sformatf("vec%0d data", i), 64'(data), 64'(vecs[i].exp_data));
         tick();
         checkOutput($sformatf("vec%0d done one cycle", i), 64'(done), 64'h0);
      end

      // Write and start in the same idle cycle, then restart during the done cycle.
      doReset();
      writeWord(1, C_HALT, '0);
      wen = 1'b1; waddr = '0; wcmd = C_OUT; wdata = 36'h66; start = 1'b1;
      tick();
      wen = 1'b0; start = 1'b0;
      mem_cmd[0] = C_OUT; mem_data[0] = 36'h66;
      tick();
      tick();
      checkOutput("wr+start data edge2", 64'(data), 64'h66);
      tick();
      tick();
      checkOutput("wr+start done edge4", 64'(done), 64'h1);
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("restart in done cycle busy", 64'(busy), 64'h1);
      runUntilDone(20, e);
      checkOutput("restart done edge", 64'(e), 64'h4);

      // Abort of an endless OUT/JUMP loop.
      doReset();
      writeWord(0, C_OUT, 36'h2);
      writeWord(1, C_JUMP, 36'h0);
      applyStimulus();
      for (int k = 1; k <= 9; k++) tick();
      checkOutput("abort pre busy", 64'(busy), 64'h1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checkOutput("abort busy", 64'(busy), 64'h0);
      checkOutput("abort done", 64'(done), 64'h0);
      checkOutput("abort data", 64'(data), 64'h2);
      tick();
      checkOutput("abort stays idle", 64'(busy), 64'h0);
      checkOutput("abort no late done", 64'(done), 64'h0);

      // Write and start while busy are both ignored.
      doReset();
      writeWord(0, C_WAIT, 36'd20);
      writeWord(1, C_OUT, 36'h11);
      writeWord(2, C_HALT, '0);
      applyStimulus();
      for (int k = 1; k <= 3; k++) tick();
      wen = 1'b1; waddr = 9'd1; wcmd = C_OUT; wdata = 36'h99; start = 1'b1;
      tick();
      wen = 1'b0; start = 1'b0;
      runUntilDone(60, e);
      checkOutput("busy-ignore done edge", 64'(e), 64'd22);
      checkOutput("busy-ignore data", 64'(data), 64'h11);
      doReset();
      applyStimulus();
      runUntilDone(60, e);
      checkOutput("readback done edge", 64'(e), 64'd26);
      checkOutput("readback data", 64'(data), 64'h11);

      // Reset in the middle of a WAIT, then a clean rerun.
      doReset();
      writeWord(0, C_OUT, 36'h44);
      writeWord(1, C_WAIT, 36'd10);
      writeWord(2, C_OUT, 36'h5);
      writeWord(3, C_HALT, '0);
      applyStimulus();
      for (int k = 1; k <= 7; k++) tick();
      checkOutput("midwait busy", 64'(busy), 64'h1);
      checkOutput("midwait data", 64'(data), 64'h44);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkOutput("midwait rst busy", 64'(busy), 64'h0);
      checkOutput("midwait rst done", 64'(done), 64'h0);
      checkOutput("midwait rst data", 64'(data), 64'h0);
      checkOutput("midwait rst pc",   64'(pc),   64'h0);
      applyStimulus();
      runUntilDone(60, e);
      checkOutput("rerun done edge", 64'(e), 64'd18);
      checkOutput("rerun data", 64'(data), 64'h5);

      // PC wrap from the last address back to 0, with junk above the jump target bits.
      writeWord(0, C_JUMP, 36'hABC_0001FE);
      writeWord(510, C_OUT, 36'hB);
      writeWord(511, C_NOP, '0);
      runModelCheck("wrap", 30);

      // The same four-instruction loop program through the model.
      writeWord(0, C_LSET, 36'h2);
      writeWord(1, C_OUT, 36'h7);
      writeWord(2, C_LBCK, 36'h1);
      writeWord(3, C_HALT, '0);
      runModelCheck("loop", 60);

      for (int p = 0; p < 20; p++) begin
         genProgram();
         runModelCheck($sformatf("rnd%0d", p), 120);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
